// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Tracks per-stage valid bits so bubbles never stall or forward, and keeps saturating counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned RF_BYPASS  = 1,
  parameter int unsigned BR_STAGE   = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic [REG_ADDR_W-1:0] wb_waddr,
  input  logic                  ex_reg_write,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [3:0]            stage_valid,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic [3:0]       valid_q, valid_d;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q, retire_q;
  logic             ex_prod, mem_prod, wb_prod;
  logic             hit_ex, hit_mem, hit_wb;
  logic             stall, flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != {CNT_W{1'b1}})) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  always_comb begin
    // Producers must be live, writing, and not targeting r0.
    ex_prod  = valid_q[1] && ex_reg_write  && (ex_waddr  != '0);
    mem_prod = valid_q[2] && mem_reg_write && (mem_waddr != '0);
    wb_prod  = valid_q[3] && wb_reg_write  && (wb_waddr  != '0);
    hit_ex   = (id_uses_rs && (id_rs == ex_waddr))  || (id_uses_rt && (id_rt == ex_waddr));
    hit_mem  = (id_uses_rs && (id_rs == mem_waddr)) || (id_uses_rt && (id_rt == mem_waddr));
    hit_wb   = (id_uses_rs && (id_rs == wb_waddr))  || (id_uses_rt && (id_rt == wb_waddr));
    if (FWD_EN != 0) begin
      stall = ex_prod && ex_mem_read && hit_ex;
    end else begin
      stall = (ex_prod && hit_ex) || (mem_prod && hit_mem) ||
              ((RF_BYPASS == 0) && wb_prod && hit_wb);
    end
    flush = br_taken && ((BR_STAGE == 2) ? valid_q[1] : valid_q[2]);
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    fwd_a_sel    = 2'b00;
    fwd_b_sel    = 2'b00;
    if (!srst) begin
      if (enable) begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        // The stalled ID instruction is younger than the branch, so a flush wins.
        if (flush) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = (BR_STAGE != 2);
        end else if (stall) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      if ((FWD_EN != 0) && valid_q[1]) begin
        if (mem_prod && (mem_waddr == ex_rs)) begin
          fwd_a_sel = 2'b01;
        end else if (wb_prod && (wb_waddr == ex_rs)) begin
          fwd_a_sel = 2'b10;
        end
        if (mem_prod && (mem_waddr == ex_rt)) begin
          fwd_b_sel = 2'b01;
        end else if (wb_prod && (wb_waddr == ex_rt)) begin
          fwd_b_sel = 2'b10;
        end
      end
    end
  end

  always_comb begin
    if (flush) begin
      valid_d = {valid_q[2], (BR_STAGE == 2) ? valid_q[1] : 1'b0, 2'b00};
    end else if (stall) begin
      valid_d = {valid_q[2], valid_q[1], 1'b0, valid_q[0]};
    end else begin
      valid_d = {valid_q[2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_q  <= '0;
      cycle_q  <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
    end else if (enable) begin
      valid_q  <= valid_d;
      cycle_q  <= sat_inc(cycle_q, 1'b1);
      stall_q  <= sat_inc(stall_q, stall && !flush);
      flush_q  <= sat_inc(flush_q, flush);
      retire_q <= sat_inc(retire_q, valid_q[3]);
    end
  end

  assign stage_valid = valid_q;
  assign cycle_cnt   = cycle_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl: two configurations checked every cycle
// against a stage-occupancy reference model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst, enable, id_uses_rs, id_uses_rt;
  logic       ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read, br_taken;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_waddr, mem_waddr, wb_waddr;

  logic       pc_en [2];
  logic       if_id_en [2];
  logic       id_ex_en [2];
  logic       ex_mem_en [2];
  logic       mem_wb_en [2];
  logic       if_id_flush [2];
  logic       id_ex_flush [2];
  logic       ex_mem_flush [2];
  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic [3:0] sv [2];
  logic [31:0] c0 [4];
  logic [3:0]  c1 [4];

  // dut0: forwarding, branch in MEM, 32-bit counters. dut1: no forwarding, no RF bypass,
  // branch in EX, 4-bit counters so saturation is reachable.
  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1), .RF_BYPASS(1), .BR_STAGE(3), .CNT_W(32)) dut0 (
    .clk(clk), .srst(srst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .br_taken(br_taken), .pc_en(pc_en[0]), .if_id_en(if_id_en[0]),
    .id_ex_en(id_ex_en[0]), .ex_mem_en(ex_mem_en[0]), .mem_wb_en(mem_wb_en[0]),
    .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]), .ex_mem_flush(ex_mem_flush[0]),
    .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]), .stage_valid(sv[0]), .cycle_cnt(c0[0]),
    .stall_cnt(c0[1]), .flush_cnt(c0[2]), .retire_cnt(c0[3])
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(0), .RF_BYPASS(0), .BR_STAGE(2), .CNT_W(4)) dut1 (
    .clk(clk), .srst(srst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .br_taken(br_taken), .pc_en(pc_en[1]), .if_id_en(if_id_en[1]),
    .id_ex_en(id_ex_en[1]), .ex_mem_en(ex_mem_en[1]), .mem_wb_en(mem_wb_en[1]),
    .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]), .ex_mem_flush(ex_mem_flush[1]),
    .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]), .stage_valid(sv[1]), .cycle_cnt(c1[0]),
    .stall_cnt(c1[1]), .flush_cnt(c1[2]), .retire_cnt(c1[3])
  );

  int cfg_fwd [2] = '{1, 0};
  int cfg_byp [2] = '{1, 0};
  int cfg_br  [2] = '{3, 2};
  longint cfg_max [2] = '{64'hFFFF_FFFF, 15};

  int n_chk = 0;
  int n_fail = 0;

  // Model: occupancy of ID/EX/MEM/WB as booleans, counters as plain integers.
  bit     occ [2][4];
  longint m_c [2][4];
  logic [4:0] e_en [2];
  logic [2:0] e_fl [2];
  logic [1:0] e_fa [2];
  logic [1:0] e_fb [2];
  bit e_stall [2];
  bit e_flush [2];

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] a);
    return (id_uses_rs && id_rs == a) || (id_uses_rt && id_rt == a);
  endfunction

  function automatic logic [1:0] fwd_src(input int k, input logic [4:0] src);
    bit mp, wp;
    mp = occ[k][2] && mem_reg_write && mem_waddr != 0 && mem_waddr == src;
    wp = occ[k][3] && wb_reg_write && wb_waddr != 0 && wb_waddr == src;
    if (srst || cfg_fwd[k] == 0 || !occ[k][1]) return 2'b00;
    if (mp) return 2'b01;
    if (wp) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_comb(input int k);
    bit pe, pm, pw;
    pe = occ[k][1] && ex_reg_write && ex_waddr != 0 && reads(ex_waddr);
    pm = occ[k][2] && mem_reg_write && mem_waddr != 0 && reads(mem_waddr);
    pw = occ[k][3] && wb_reg_write && wb_waddr != 0 && reads(wb_waddr);
    if (cfg_fwd[k] != 0) e_stall[k] = pe && ex_mem_read;
    else e_stall[k] = pe || pm || (cfg_byp[k] == 0 && pw);
    e_flush[k] = br_taken && occ[k][cfg_br[k] - 1];
    if (srst || !enable) begin
      e_en[k] = 5'b00000;
      e_fl[k] = 3'b000;
    end else if (e_flush[k]) begin
      e_en[k] = 5'b11111;
      e_fl[k] = {1'b1, 1'b1, cfg_br[k] == 3};
    end else if (e_stall[k]) begin
      e_en[k] = 5'b00111;
      e_fl[k] = 3'b010;
    end else begin
      e_en[k] = 5'b11111;
      e_fl[k] = 3'b000;
    end
    e_fa[k] = fwd_src(k, ex_rs);
    e_fb[k] = fwd_src(k, ex_rt);
  endtask

  function automatic logic [63:0] act_cnt(input int k, input int i);
    return (k == 0) ? 64'(c0[i]) : 64'(c1[i]);
  endfunction

  function automatic longint bump(input int k, input longint c, input bit inc);
    return (inc && c < cfg_max[k]) ? c + 1 : c;
  endfunction

  // Compare at the falling edge, then advance the model across the next rising edge.
  task automatic tick();
    bit     nocc [2][4];
    longint nc [2][4];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_comb(k);
      chk("enables", k, 64'({pc_en[k], if_id_en[k], id_ex_en[k], ex_mem_en[k], mem_wb_en[k]}),
          64'(e_en[k]));
      chk("flushes", k, 64'({if_id_flush[k], id_ex_flush[k], ex_mem_flush[k]}), 64'(e_fl[k]));
      chk("fwd_a_sel", k, 64'(fa[k]), 64'(e_fa[k]));
      chk("fwd_b_sel", k, 64'(fb[k]), 64'(e_fb[k]));
      chk("stage_valid", k, 64'(sv[k]), 64'({occ[k][3], occ[k][2], occ[k][1], occ[k][0]}));
      for (int i = 0; i < 4; i++) chk("counter", k, act_cnt(k, i), 64'(m_c[k][i]));
      for (int i = 0; i < 4; i++) begin
        nocc[k][i] = occ[k][i];
        nc[k][i]   = m_c[k][i];
      end
      if (srst) begin
        for (int i = 0; i < 4; i++) begin
          nocc[k][i] = 1'b0;
          nc[k][i]   = 0;
        end
      end else if (enable) begin
        nc[k][0] = bump(k, m_c[k][0], 1'b1);
        nc[k][1] = bump(k, m_c[k][1], e_stall[k] && !e_flush[k]);
        nc[k][2] = bump(k, m_c[k][2], e_flush[k]);
        nc[k][3] = bump(k, m_c[k][3], occ[k][3]);
        nocc[k][3] = occ[k][2];
        if (e_flush[k]) begin
          nocc[k][2] = (cfg_br[k] == 2) ? occ[k][1] : 1'b0;
          nocc[k][1] = 1'b0;
          nocc[k][0] = 1'b0;
        end else if (e_stall[k]) begin
          nocc[k][2] = occ[k][1];
          nocc[k][1] = 1'b0;
        end else begin
          nocc[k][2] = occ[k][1];
          nocc[k][1] = occ[k][0];
          nocc[k][0] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        occ[k][i] = nocc[k][i];
        m_c[k][i] = nc[k][i];
      end
  endtask

  task automatic clear_in();
    srst = 0; enable = 1; id_uses_rs = 0; id_uses_rt = 0; ex_reg_write = 0;
    mem_reg_write = 0; wb_reg_write = 0; ex_mem_read = 0; br_taken = 0;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_waddr = 0; mem_waddr = 0; wb_waddr = 0;
  endtask

  task automatic reset_fill();
    clear_in(); srst = 1; tick();
    clear_in(); repeat (4) tick();
  endtask

  task automatic rand_in();
    srst = ($urandom_range(0, 199) == 0);
    enable = ($urandom_range(0, 9) != 0);
    id_uses_rs = 1'($urandom_range(0, 1));
    id_uses_rt = 1'($urandom_range(0, 1));
    ex_reg_write = 1'($urandom_range(0, 1));
    mem_reg_write = 1'($urandom_range(0, 1));
    wb_reg_write = 1'($urandom_range(0, 1));
    ex_mem_read = 1'($urandom_range(0, 1));
    br_taken = ($urandom_range(0, 7) == 0);
    id_rs = 5'($urandom_range(0, 7));
    id_rt = 5'($urandom_range(0, 7));
    ex_rs = 5'($urandom_range(0, 7));
    ex_rt = 5'($urandom_range(0, 7));
    ex_waddr = 5'($urandom_range(0, 7));
    mem_waddr = 5'($urandom_range(0, 7));
    wb_waddr = 5'($urandom_range(0, 7));
  endtask

  logic [3:0] fill_seq [5] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF};

  initial begin
    clear_in();
    srst = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        occ[k][i] = 1'b0;
        m_c[k][i] = 0;
      end
    chk("reset stage_valid", 0, 64'(sv[0]), 64'h0);
    chk("reset cycle_cnt", 0, 64'(c0[0]), 64'h0);
    tick();

    // Fill with no hazards.
    clear_in();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fill stage_valid", 0, 64'(sv[0]), 64'(fill_seq[i]));
    end
    chk("fill cycle_cnt", 0, 64'(c0[0]), 64'd5);
    chk("fill retire_cnt", 0, 64'(c0[3]), 64'd1);

    // Forwarding priority.
    mem_reg_write = 1; mem_waddr = 8; wb_reg_write = 1; wb_waddr = 8; ex_rs = 8;
    #1;
    chk("fwd mem", 0, 64'(fa[0]), 64'h1);
    chk("fwd off", 1, 64'(fa[1]), 64'h0);
    tick();
    mem_reg_write = 0;
    #1;
    chk("fwd wb", 0, 64'(fa[0]), 64'h2);
    tick();
    ex_rs = 0;
    #1;
    chk("fwd r0", 0, 64'(fa[0]), 64'h0);
    tick();

    // Load-use stall.
    clear_in();
    ex_reg_write = 1; ex_mem_read = 1; ex_waddr = 5; id_uses_rt = 1; id_rt = 5;
    #1;
    chk("lu pc_en", 0, 64'(pc_en[0]), 64'h0);
    chk("lu if_id_en", 0, 64'(if_id_en[0]), 64'h0);
    chk("lu id_ex_flush", 0, 64'(id_ex_flush[0]), 64'h1);
    tick();
    chk("lu stage_valid", 0, 64'(sv[0]), 64'hD);
    chk("lu stall_cnt", 0, 64'(c0[1]), 64'd1);
    #1;
    chk("lu released", 0, 64'(pc_en[0]), 64'h1);
    tick();
    ex_reg_write = 0; ex_mem_read = 0; ex_rt = 5; wb_reg_write = 1; wb_waddr = 5;
    #1;
    chk("lu fwd_b", 0, 64'(fb[0]), 64'h2);
    tick();
    chk("lu stall_cnt hold", 0, 64'(c0[1]), 64'd1);

    // No-forwarding, no-bypass: consumer waits for the producer to pass EX, MEM and WB.
    reset_fill();
    clear_in(); id_uses_rs = 1; id_rs = 3; ex_reg_write = 1; ex_waddr = 3;
    #1; chk("nf stall ex", 1, 64'(pc_en[1]), 64'h0); tick();
    clear_in(); id_uses_rs = 1; id_rs = 3; mem_reg_write = 1; mem_waddr = 3;
    #1; chk("nf stall mem", 1, 64'(pc_en[1]), 64'h0); tick();
    clear_in(); id_uses_rs = 1; id_rs = 3; wb_reg_write = 1; wb_waddr = 3;
    #1; chk("nf stall wb", 1, 64'(pc_en[1]), 64'h0); tick();
    chk("nf stage_valid", 1, 64'(sv[1]), 64'h1);
    clear_in(); id_uses_rs = 1; id_rs = 3;
    #1; chk("nf proceed", 1, 64'(pc_en[1]), 64'h1); tick();
    chk("nf stall_cnt", 1, 64'(act_cnt(1, 1)), 64'd3);

    // Branch in MEM during a load-use stall: flush wins.
    reset_fill();
    ex_reg_write = 1; ex_mem_read = 1; ex_waddr = 5; id_uses_rt = 1; id_rt = 5; br_taken = 1;
    #1;
    chk("br flushes", 0, 64'({if_id_flush[0], id_ex_flush[0], ex_mem_flush[0]}), 64'h7);
    chk("br pc_en", 0, 64'(pc_en[0]), 64'h1);
    tick();
    chk("br stage_valid", 0, 64'(sv[0]), 64'h8);
    chk("br flush_cnt", 0, 64'(c0[2]), 64'd1);
    chk("br stall_cnt", 0, 64'(c0[1]), 64'd0);

    // Freeze.
    br_taken = 0; enable = 0;
    #1;
    chk("frz enables", 0, 64'({pc_en[0], if_id_en[0], id_ex_en[0], ex_mem_en[0], mem_wb_en[0]}),
        64'h0);
    repeat (3) tick();
    chk("frz cycle_cnt", 0, 64'(c0[0]), 64'd5);
    chk("frz stage_valid", 0, 64'(sv[0]), 64'h8);

    // Mid-run reset.
    repeat (20) begin rand_in(); srst = 0; tick(); end
    rand_in(); srst = 1; enable = 1; tick();
    chk("srst stage_valid", 0, 64'(sv[0]), 64'h0);
    chk("srst cycle_cnt", 0, 64'(c0[0]), 64'h0);
    chk("srst retire_cnt", 1, 64'(act_cnt(1, 3)), 64'h0);

    // Random run; dut1's 4-bit counters saturate between the rare resets.
    repeat (3000) begin rand_in(); tick(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
